// File: rtl/scale_pkg.sv
// Shared widths, share counts and collector state type for the share collector slice.
package scale_pkg;

  localparam int unsigned COEFF_W          = 30;
  localparam int unsigned ADDR_W           = 3;
  localparam int unsigned NUM_SHARES_SMALL = 6;
  localparam int unsigned NUM_SHARES_BIG   = 7;
  // Wide enough for seven full-scale shares.
  localparam int unsigned SUM_W            = 33;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDrain
  } state_e;

  // Number of shares in a set for the given lift size (0 = small, 1 = big).
  function automatic logic [ADDR_W-1:0] share_count(input logic big);
    return big ? ADDR_W'(NUM_SHARES_BIG) : ADDR_W'(NUM_SHARES_SMALL);
  endfunction

endpackage

// File: rtl/share_regfile.sv
// Seven-entry share storage with a written-bitmap; one write port, one read port.
module share_regfile
  import scale_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we_i,
  input  logic [ADDR_W-1:0]         waddr_i,
  input  logic [COEFF_W-1:0]        wdata_i,
  input  logic                      clr_i,
  input  logic [ADDR_W-1:0]         raddr_i,
  output logic [COEFF_W-1:0]        rdata_o,
  output logic [NUM_SHARES_BIG-1:0] bitmap_o
);

  logic [COEFF_W-1:0]        mem_q [NUM_SHARES_BIG];
  logic [NUM_SHARES_BIG-1:0] bitmap_q;

  // Share storage; contents are only read once every slot of the set was rewritten.
  always_ff @(posedge clk) begin
    if (we_i && (waddr_i < ADDR_W'(NUM_SHARES_BIG))) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Written bitmap; cleared on reset and when a set finishes draining.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      bitmap_q <= '0;
    end else if (we_i && (waddr_i < ADDR_W'(NUM_SHARES_BIG))) begin
      bitmap_q[waddr_i] <= 1'b1;
    end
  end

  // Asynchronous read of the presented share.
  always_comb begin
    rdata_o = '0;
    if (raddr_i < ADDR_W'(NUM_SHARES_BIG)) begin
      rdata_o = mem_q[raddr_i];
    end
  end

  assign bitmap_o = bitmap_q;

endmodule

// File: rtl/scale_share_collector.sv
// Collects a set of 6 or 7 scaled shares written in any order, then drains them in
// ascending index order over a valid/ready port. Optional running sum of the drained
// shares is enabled by defining SCALE_SHARE_SUM_EN.
module scale_share_collector
  import scale_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic               in_we,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [COEFF_W-1:0] in_coeff,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [COEFF_W-1:0] out_coeff,
  output logic               out_last,
  output logic               err_dup,
  output logic               err_range,
  output logic               err_overrun
`ifdef SCALE_SHARE_SUM_EN
  ,
  output logic               sum_valid,
  output logic [SUM_W-1:0]   sum_out
`endif
);

  state_e                    state_q, state_d;
  logic                      big_q;
  logic [ADDR_W-1:0]         rd_idx_q;
  logic                      err_dup_q, err_range_q, err_overrun_q;
  logic [NUM_SHARES_BIG-1:0] bitmap, onehot, bitmap_nxt, need_mask;
  logic [COEFF_W-1:0]        rdata;
  logic [ADDR_W-1:0]         limit, n_cur;
  logic                      accept, complete, handshake, at_last;

  // Write qualification, set completion and drain handshake decode.
  always_comb begin
    n_cur      = share_count(big_q);
    // In IDLE the set size is not latched yet, so check against the incoming mode.
    limit      = (state_q == StIdle) ? share_count(mode) : n_cur;
    accept     = in_we && (state_q != StDrain) && (in_addr < limit);
    onehot     = accept ? (NUM_SHARES_BIG'(1) << in_addr) : '0;
    bitmap_nxt = bitmap | onehot;
    need_mask  = big_q ? 7'h7f : 7'h3f;
    complete   = (state_q == StCollect) && accept && (&(bitmap_nxt | ~need_mask));
    handshake  = out_valid && out_ready;
    at_last    = (rd_idx_q == ADDR_W'(n_cur - ADDR_W'(1)));
  end

  share_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (accept),
    .waddr_i  (in_addr),
    .wdata_i  (in_coeff),
    .clr_i    (handshake && at_last),
    .raddr_i  (rd_idx_q),
    .rdata_o  (rdata),
    .bitmap_o (bitmap)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StCollect;
      StCollect: if (complete) state_d = StDrain;
      StDrain:   if (handshake && at_last) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs; the presented share is a pure function of the drain pointer, so it holds
  // steady while the consumer stalls.
  always_comb begin
    out_valid = (state_q == StDrain);
    out_addr  = rd_idx_q;
    out_coeff = out_valid ? rdata : '0;
    out_last  = out_valid && at_last;
  end

  // Set size latch, drain pointer and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      big_q         <= 1'b0;
      rd_idx_q      <= '0;
      err_dup_q     <= 1'b0;
      err_range_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      if ((state_q == StIdle) && accept) big_q <= mode;
      if (handshake) rd_idx_q <= at_last ? '0 : rd_idx_q + ADDR_W'(1);
      if (accept && bitmap[in_addr]) err_dup_q <= 1'b1;
      if (in_we && (state_q != StDrain) && (in_addr >= limit)) err_range_q <= 1'b1;
      if (in_we && (state_q == StDrain)) err_overrun_q <= 1'b1;
    end
  end

  assign err_dup     = err_dup_q;
  assign err_range   = err_range_q;
  assign err_overrun = err_overrun_q;

`ifdef SCALE_SHARE_SUM_EN
  logic [SUM_W-1:0] acc_q;
  logic             sum_valid_q;

  // Running total of drained shares; pulses valid the cycle after the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      if (complete) begin
        acc_q <= '0;
      end else if (handshake) begin
        acc_q <= acc_q + SUM_W'(out_coeff);
      end
      sum_valid_q <= handshake && at_last;
    end
  end

  assign sum_valid = sum_valid_q;
  assign sum_out   = acc_q;
`endif

endmodule

// File: tb/tb_scale_share_collector.sv
// Directed bench for scale_share_collector: a set-level model checked every cycle plus
// hand-computed expectations per scenario. Sum checks follow SCALE_SHARE_SUM_EN.
module tb_scale_share_collector;

  logic        clk = 1'b0;
  logic        rst, mode, in_we, out_ready;
  logic [2:0]  in_addr;
  logic [29:0] in_coeff;
  logic        out_valid, out_last, err_dup, err_range, err_overrun;
  logic [2:0]  out_addr;
  logic [29:0] out_coeff;
`ifdef SCALE_SHARE_SUM_EN
  logic        sum_valid;
  logic [32:0] sum_out;
`endif

  scale_share_collector dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .in_we       (in_we),
    .in_addr     (in_addr),
    .in_coeff    (in_coeff),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_coeff   (out_coeff),
    .out_last    (out_last),
    .err_dup     (err_dup),
    .err_range   (err_range),
    .err_overrun (err_overrun)
`ifdef SCALE_SHARE_SUM_EN
    ,
    .sum_valid   (sum_valid),
    .sum_out     (sum_out)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Set-level model: phase 0 idle, 1 collecting, 2 draining.
  int          ph = 0;
  int          m_n = 6;
  int          m_ptr = 0;
  logic [29:0] m_val [7];
  logic [6:0]  m_wr = '0;
  bit          m_dup, m_rng, m_ovr, m_sv;
  logic [32:0] m_sum = '0;
  bit          chk_en = 1'b0;

  // Log of accepted beats as seen on the DUT port, for literal checks.
  int          log_a [$];
  logic [29:0] log_c [$];
  bit          log_l [$];
  logic [32:0] last_sum = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, ph == 2);
      if (ph == 2) begin
        chk("out_addr", out_addr, m_ptr);
        chk("out_coeff", out_coeff, m_val[m_ptr]);
        chk("out_last", out_last, m_ptr == m_n - 1);
      end else begin
        chk("out_last_idle", out_last, 0);
      end
      chk("err_dup", err_dup, m_dup);
      chk("err_range", err_range, m_rng);
      chk("err_overrun", err_overrun, m_ovr);
`ifdef SCALE_SHARE_SUM_EN
      chk("sum_valid", sum_valid, m_sv);
      if (m_sv) begin
        chk("sum_out", sum_out, m_sum);
        last_sum = sum_out;
      end
`endif
      if (!rst && out_valid && out_ready) begin
        log_a.push_back(int'(out_addr));
        log_c.push_back(out_coeff);
        log_l.push_back(out_last);
      end
    end
    // Advance the model with the inputs the DUT samples at the coming edge.
    if (rst) begin
      ph = 0; m_wr = '0; m_ptr = 0; m_sum = '0;
      m_dup = 0; m_rng = 0; m_ovr = 0; m_sv = 0;
    end else begin
      m_sv = 0;
      if (ph == 2) begin
        if (in_we) m_ovr = 1;
        if (out_ready) begin
          m_sum = m_sum + 33'(m_val[m_ptr]);
          if (m_ptr == m_n - 1) begin
            ph = 0; m_wr = '0; m_ptr = 0; m_sv = 1;
          end else begin
            m_ptr++;
          end
        end
      end else if (in_we) begin
        int lim;
        bit all;
        lim = (ph == 0) ? (mode ? 7 : 6) : m_n;
        if (int'(in_addr) >= lim) begin
          m_rng = 1;
        end else begin
          if (ph == 0) m_n = lim;
          if (m_wr[in_addr]) m_dup = 1;
          m_val[in_addr] = in_coeff;
          m_wr[in_addr] = 1'b1;
          ph = 1;
          all = 1;
          for (int i = 0; i < m_n; i++) if (!m_wr[i]) all = 0;
          if (all) begin
            ph = 2; m_ptr = 0; m_sum = '0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [29:0] c);
    in_we = 1'b1; in_addr = a; in_coeff = c;
    tick();
    in_we = 1'b0;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_a.delete(); log_c.delete(); log_l.delete();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int cnt = 0;
    while (log_a.size() < n && cnt < budget) begin
      tick();
      cnt++;
    end
    chk("beat_count", log_a.size(), n);
  endtask

  // Beat i must carry address i, value base+i, and last only on the final beat.
  task automatic check_log(input int n, input int base);
    for (int i = 0; i < n && i < log_a.size(); i++) begin
      chk("log_addr", log_a[i], i);
      chk("log_coeff", log_c[i], base + i);
      chk("log_last", log_l[i], i == n - 1);
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; in_we = 1'b0; out_ready = 1'b0;
    in_addr = '0; in_coeff = '0;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    at_neg();
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_coeff", out_coeff, 0);
    chk("rst_errs", {err_dup, err_range, err_overrun}, 0);
    tick();

    // Small set in order, consumer always ready.
    clear_log();
    mode = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) wr(3'(i), 30'(100 + i));
    at_neg();
    chk("s1_valid_after_last_write", out_valid, 1);
    tick();
    wait_beats(6, 20);
    check_log(6, 100);
    at_neg();
    chk("s1_idle_after", out_valid, 0);
    tick();

    // Big set written in reverse with full-scale values, stalled for three cycles.
    clear_log();
    mode = 1'b1; out_ready = 1'b0;
    for (int i = 6; i >= 0; i--) wr(3'(i), 30'h3fff_ffff);
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("s2_hold_valid", out_valid, 1);
      chk("s2_hold_addr", out_addr, 0);
      chk("s2_hold_coeff", out_coeff, 30'h3fff_ffff);
      chk("s2_hold_last", out_last, 0);
      tick();
    end
    out_ready = 1'b1;
    wait_beats(7, 20);
    for (int i = 0; i < 7 && i < log_a.size(); i++) begin
      chk("s2_addr", log_a[i], i);
      chk("s2_coeff", log_c[i], 30'h3fff_ffff);
      chk("s2_last", log_l[i], i == 6);
    end
    tick();
`ifdef SCALE_SHARE_SUM_EN
    chk("s2_sum", last_sum, 33'd7516192761);
`endif

    // Duplicate write overwrites and flags.
    pulse_rst();
    clear_log();
    mode = 1'b0; out_ready = 1'b1;
    wr(3'd2, 30'd7);
    wr(3'd2, 30'd9);
    at_neg();
    chk("s3_err_dup", err_dup, 1);
    tick();
    wr(3'd0, 30'd10); wr(3'd1, 30'd11); wr(3'd3, 30'd13); wr(3'd4, 30'd14); wr(3'd5, 30'd15);
    wait_beats(6, 20);
    if (log_c.size() > 2) chk("s3_idx2_value", log_c[2], 9);

    // Out-of-range write is ignored; set stays incomplete until idx5 arrives.
    pulse_rst();
    clear_log();
    mode = 1'b0; out_ready = 1'b1;
    wr(3'd0, 30'd20);
    wr(3'd6, 30'd55);
    at_neg();
    chk("s4_err_range", err_range, 1);
    tick();
    for (int i = 1; i < 5; i++) wr(3'(i), 30'(20 + i));
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("s4_still_collecting", out_valid, 0);
      tick();
    end
    wr(3'd5, 30'd25);
    wait_beats(6, 20);
    check_log(6, 20);

    // Write during drain is dropped and flagged.
    pulse_rst();
    clear_log();
    mode = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) wr(3'(i), 30'(200 + i));
    wr(3'd0, 30'd999);
    at_neg();
    chk("s5_err_overrun", err_overrun, 1);
    tick();
    out_ready = 1'b1;
    wait_beats(6, 20);
    check_log(6, 200);

    // Reset mid-collect discards the partial set and its bitmap.
    clear_log();
    wr(3'd0, 30'd300); wr(3'd1, 30'd301); wr(3'd2, 30'd302);
    pulse_rst();
    wr(3'd3, 30'd503); wr(3'd4, 30'd504); wr(3'd5, 30'd505);
    for (int k = 0; k < 2; k++) begin
      at_neg();
      chk("s6_no_stale_complete", out_valid, 0);
      tick();
    end
    wr(3'd0, 30'd500); wr(3'd1, 30'd501); wr(3'd2, 30'd502);
    wait_beats(6, 20);
    check_log(6, 500);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/scale_share_collector.md
SCALE_SHARE_COLLECTOR -- requirements
Module: scale_share_collector

Interface
REQ-001 SHALL have: clk  input  1  clock; all logic on the rising edge.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: mode  input  1  0 = 6-share set (small lift), 1 = 7-share set (big lift); sampled on the first accepted write of a set.
REQ-004 SHALL have: in_we  input  1  share write strobe from the scaler.
REQ-005 SHALL have: in_addr  input  3  share index.
REQ-006 SHALL have: in_coeff  input  30  scaled, reduced share value.
REQ-007 SHALL have: out_valid  output  1  drained share available.
REQ-008 SHALL have: out_ready  input  1  downstream accepts the share.
REQ-009 SHALL have: out_addr  output  3  index of the presented share.
REQ-010 SHALL have: out_coeff  output  30  value of the presented share.
REQ-011 SHALL have: out_last  output  1  the presented share is the final one of the set.
REQ-012 SHALL have: err_dup  output  1  sticky; a share index was written twice in one set.
REQ-013 SHALL have: err_range  output  1  sticky; in_addr was at or above the share count.
REQ-014 SHALL have: err_overrun  output  1  sticky; a write arrived during DRAIN.

Function
REQ-015 SHALL implement states IDLE, COLLECT and DRAIN.
REQ-016 SHALL move IDLE->COLLECT on the first in_we with a valid address, storing the share and latching mode as N (6 or 7).
REQ-017 SHALL, in COLLECT, store in_coeff at in_addr and set that bit in a 7-bit written bitmap on each in_we.
REQ-018 SHALL enter DRAIN in the cycle after the write that completes bitmap[N-1:0]; out_valid SHALL then be high.
REQ-019 SHALL, in DRAIN, present shares in ascending index 0..N-1; a share advances only on out_valid and out_ready both high.
REQ-020 SHALL assert out_last only while index N-1 is presented; its handshake SHALL return the block to IDLE and clear the bitmap.
REQ-021 SHALL hold out_addr, out_coeff and out_last stable while out_valid is high and out_ready is low.
REQ-022 SHALL, on a write to an already-set bitmap bit, overwrite the stored value and set err_dup.
REQ-023 SHALL ignore a write with in_addr >= N, or >= 7 in IDLE, and set err_range; no state change otherwise.
REQ-024 SHALL drop any in_we during DRAIN and set err_overrun; the drain SHALL continue unaffected.
REQ-025 SHALL keep out_valid low in IDLE and COLLECT.
REQ-026 SHALL clear err flags only on rst.

Reset
REQ-027 SHALL on rst: state IDLE, bitmap 0, out_valid 0, out_last 0, out_addr 0, out_coeff 0, all err flags 0, sum outputs 0.
REQ-028 SHALL let rst during COLLECT or DRAIN discard the partial set with no further output.

Configuration
REQ-029 SHALL, with SCALE_SHARE_SUM_EN defined, add outputs sum_valid (1) and sum_out (33); the accumulator is cleared on entry to DRAIN and adds out_coeff on each handshake.
REQ-030 SHALL then pulse sum_valid for one cycle after the out_last handshake, with sum_out equal to the total of all N drained shares.
REQ-031 SHALL, without SCALE_SHARE_SUM_EN, omit those ports and the accumulator.

Structure
REQ-032 SHALL take COEFF_W=30, ADDR_W=3, NUM_SHARES_SMALL=6, NUM_SHARES_BIG=7 and the state enum from shared package scale_pkg.
REQ-033 SHALL implement the 7x30 storage and bitmap as sub-module share_regfile; FSM, error logic and sum stay at the top level.

Verification
REQ-034 SHALL cover: mode=0, writes idx0..5 of 100..105 on consecutive cycles, out_ready=1 -> out_valid in the cycle after idx5; six beats 100..105, out_last on idx5; then IDLE.
REQ-035 SHALL cover: mode=1, writes 6,5,4,3,2,1,0 of 2^30-1 each, out_ready=0 for 3 cycles -> outputs held; drain idx0..6 in order; with the macro, sum_out=7*(2^30-1).
REQ-036 SHALL cover: mode=0, write idx2=7 then idx2=9 -> err_dup=1, drained idx2=9.
REQ-037 SHALL cover: mode=0, write idx6 -> err_range=1, set still incomplete, out_valid stays 0.
REQ-038 SHALL cover: write during DRAIN -> err_overrun=1, drain values unchanged; and rst mid-COLLECT -> next full set drains correctly with no stale shares.
